pipeline_hazard_ctrl: RTL and testbench

Parametrised pipeline control block for the 5-stage ARM core. It merges hazard detection and forwarding-select generation, and adds a wait-state FSM that freezes the whole pipeline while a multi-cycle data-memory access occupies MEM. Branch flush is arbitrated against stalls. It also keeps saturating stall and flush performance counters. Sits beside the pipeline registers and drives their freeze, bubble and flush controls plus the EXE operand muxes.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 36 +++
 rtl/pipeline_hazard_ctrl_mem_wait.sv | 82 ++++++++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared encodings for the pipeline hazard controller: EXE
//               operand-select codes, wait-FSM state type, forwarding helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

    // EXE operand mux selects
    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // Memory wait-state FSM
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } wait_state_t;

    // MEM result is younger than WB, so it wins when both match
    function automatic logic [1:0] fwd_sel(input logic en,
                                           input logic mem_hit,
                                           input logic wb_hit);
        logic [1:0] sel;
        sel = SEL_RF;
        if (en && mem_hit) begin
            sel = SEL_MEM;
        end else if (en && wb_hit) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_mem_wait.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_fsm
// Description : Wait-state FSM that holds the pipeline while a multi-cycle
//               data-memory access occupies MEM. Each access yields exactly
//               MEM_LAT-1 stall cycles; MEM_LAT=1 never stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_fsm
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int LAT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_mem_access,
    output logic o_stall_all,
    output logic o_mem_busy
);

    // The IDLE cycle that accepts the access is the first stall cycle, so
    // WAIT only needs to cover the remaining MEM_LAT-2 stall cycles.
    localparam logic [LAT_W-1:0] c_load  = LAT_W'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    localparam logic             c_multi = (MEM_LAT > 1);

    wait_state_t      r_state;
    logic [LAT_W-1:0] r_cnt;
    logic             r_mem_busy;
    logic             w_stall;

    // State, wait counter and registered busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mem_busy <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_mem_access && c_multi) begin
                        r_state    <= WAIT;
                        r_cnt      <= c_load;
                        r_mem_busy <= 1'b1;
                    end else begin
                        r_mem_busy <= 1'b0;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state    <= IDLE;
                        r_mem_busy <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_cnt      <= '0;
                    r_mem_busy <= 1'b0;
                end
            endcase
        end
    end

    // Stall request; forced low while reset is asserted
    always_comb begin
        w_stall = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE:    w_stall = i_mem_access && c_multi;
                WAIT:    w_stall = (r_cnt != '0);
                default: w_stall = 1'b0;
            endcase
        end
    end

    assign o_stall_all = w_stall;
    assign o_mem_busy  = r_mem_busy;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : 5-stage pipeline control: operand forwarding selects, data
//               hazard detection, memory wait-state stall, branch flush
//               arbitration and saturating stall/flush performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_W   = 4,
    parameter int MEM_LAT = 1,
    parameter int LAT_W   = 8,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic [REG_W-1:0] exe_src1,
    input  logic [REG_W-1:0] exe_src2,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_access,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             wb_wb_en,
    input  logic             branch_taken,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic             freeze_if,
    output logic             bubble_id,
    output logic             flush,
    output logic             stall_all,
    output logic             mem_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             w_stall_all;
    logic             w_id_exe_hit;
    logic             w_id_mem_hit;
    logic             w_haz;
    logic             w_freeze;
    logic             w_bubble;
    logic             w_flush;
    logic             w_stall_evt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    mem_wait_fsm #(
        .MEM_LAT (MEM_LAT),
        .LAT_W   (LAT_W)
    ) u_mem_wait (
        .clk          (clk),
        .rst          (rst),
        .i_mem_access (mem_access),
        .o_stall_all  (w_stall_all),
        .o_mem_busy   (mem_busy)
    );

    // Source-vs-destination matches; id_src2 only counts when it is read
    assign w_id_exe_hit = (id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest));
    assign w_id_mem_hit = (id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest));

    // With forwarding only a load in EXE cannot be bypassed in time;
    // without it any pending write in EXE or MEM must drain first.
    assign w_haz = fwd_en ? (exe_wb_en && exe_mem_r_en && w_id_exe_hit)
                          : ((exe_wb_en && w_id_exe_hit) || (mem_wb_en && w_id_mem_hit));

    // Forwarding selects for the EXE operand muxes
    assign sel_src1 = rst ? SEL_RF
                          : fwd_sel(fwd_en, mem_wb_en && (mem_dest == exe_src1),
                                    wb_wb_en && (wb_dest == exe_src1));
    assign sel_src2 = rst ? SEL_RF
                          : fwd_sel(fwd_en, mem_wb_en && (mem_dest == exe_src2),
                                    wb_wb_en && (wb_dest == exe_src2));

    // Priority: memory stall > branch flush > data hazard. A branch seen
    // during a stall stays in EXE and is flushed once the stall releases.
    always_comb begin
        w_freeze = 1'b0;
        w_bubble = 1'b0;
        w_flush  = 1'b0;
        if (!rst) begin
            if (w_stall_all) begin
                w_freeze = 1'b1;
            end else if (branch_taken) begin
                w_flush = 1'b1;
            end else if (w_haz) begin
                w_freeze = 1'b1;
                w_bubble = 1'b1;
            end
        end
    end

    assign w_stall_evt = w_stall_all || (w_haz && !branch_taken);

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign freeze_if = w_freeze;
    assign bubble_id = w_bubble;
    assign flush     = w_flush;
    assign stall_all = w_stall_all;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl. Four instances
//               with MEM_LAT = 1, 3, 4, 5 share stimulus and are compared to a
//               cycle-level reference model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 4;
    localparam int CNT_W = 8;
    localparam int N     = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fwd_en, id_two_src, exe_wb_en, exe_mem_r_en;
    logic             mem_wb_en, mem_access, wb_wb_en, branch_taken;
    logic [REG_W-1:0] id_src1, id_src2, exe_src1, exe_src2, exe_dest;
    logic [REG_W-1:0] mem_dest, wb_dest;

    logic [1:0]       sel1_o [N];
    logic [1:0]       sel2_o [N];
    logic             freeze_o [N];
    logic             bubble_o [N];
    logic             flush_o [N];
    logic             stall_o [N];
    logic             busy_o [N];
    logic [CNT_W-1:0] scnt_o [N];
    logic [CNT_W-1:0] fcnt_o [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            pipeline_hazard_ctrl #(
                .REG_W   (REG_W),
                .MEM_LAT ((gi == 0) ? 1 : gi + 2),
                .LAT_W   (8),
                .CNT_W   (CNT_W)
            ) u_dut (
                .clk          (clk),
                .rst          (rst),
                .fwd_en       (fwd_en),
                .id_src1      (id_src1),
                .id_src2      (id_src2),
                .id_two_src   (id_two_src),
                .exe_src1     (exe_src1),
                .exe_src2     (exe_src2),
                .exe_dest     (exe_dest),
                .exe_wb_en    (exe_wb_en),
                .exe_mem_r_en (exe_mem_r_en),
                .mem_dest     (mem_dest),
                .mem_wb_en    (mem_wb_en),
                .mem_access   (mem_access),
                .wb_dest      (wb_dest),
                .wb_wb_en     (wb_wb_en),
                .branch_taken (branch_taken),
                .sel_src1     (sel1_o[gi]),
                .sel_src2     (sel2_o[gi]),
                .freeze_if    (freeze_o[gi]),
                .bubble_id    (bubble_o[gi]),
                .flush        (flush_o[gi]),
                .stall_all    (stall_o[gi]),
                .mem_busy     (busy_o[gi]),
                .stall_cnt    (scnt_o[gi]),
                .flush_cnt    (fcnt_o[gi])
            );
        end
    endgenerate

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: cycles elapsed since the current access was
    // accepted (-1 when no access is in progress) and expected counters.
    int phase [N];
    int mscnt [N];
    int mfcnt [N];
    // Observations from the most recent cycle, for directed tallies
    logic [1:0] seen_sel1;
    logic       seen_stall [N];
    logic       seen_busy  [N];
    logic       seen_flush [N];
    logic       seen_freeze [N];
    logic       seen_bubble [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : i + 2;
    endfunction

    function automatic logic [1:0] fwd_model(input logic [REG_W-1:0] src);
        if (!fwd_en) return 2'd0;
        if (mem_wb_en && mem_dest == src) return 2'd1;
        if (wb_wb_en && wb_dest == src) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit reads(input logic [REG_W-1:0] r);
        return (id_src1 == r) || (id_two_src && id_src2 == r);
    endfunction

    function automatic bit haz_model();
        if (fwd_en) return exe_wb_en && exe_mem_r_en && reads(exe_dest);
        return (exe_wb_en && reads(exe_dest)) || (mem_wb_en && reads(mem_dest));
    endfunction

    // One clock cycle: sample mid-cycle, compare, then advance the model at the edge.
    task automatic run_cycle();
        logic [1:0] e1, e2;
        bit haz, es, efl, efr, eb, ebusy;
        bit inc_s [N];
        bit inc_f [N];
        int L;
        #4;
        e1  = rst ? 2'd0 : fwd_model(exe_src1);
        e2  = rst ? 2'd0 : fwd_model(exe_src2);
        haz = haz_model();
        seen_sel1 = sel1_o[0];
        for (int i = 0; i < N; i++) begin
            L = lat_of(i);
            if (rst) begin
                phase[i] = -1;
                mscnt[i] = 0;
                mfcnt[i] = 0;
            end else if (phase[i] < 0 && mem_access && L > 1) begin
                phase[i] = 0;
            end
            es    = !rst && phase[i] >= 0 && phase[i] < L - 1;
            ebusy = phase[i] >= 1;
            efl   = !rst && !es && branch_taken;
            efr   = !rst && (es || (!branch_taken && haz));
            eb    = !rst && !es && !branch_taken && haz;
            inc_s[i] = !rst && (es || (haz && !branch_taken));
            inc_f[i] = efl;
            check($sformatf("sel_src1_L%0d", L), sel1_o[i], e1);
            check($sformatf("sel_src2_L%0d", L), sel2_o[i], e2);
            check($sformatf("stall_all_L%0d", L), stall_o[i], es);
            check($sformatf("mem_busy_L%0d", L), busy_o[i], ebusy);
            check($sformatf("flush_L%0d", L), flush_o[i], efl);
            check($sformatf("freeze_if_L%0d", L), freeze_o[i], efr);
            check($sformatf("bubble_id_L%0d", L), bubble_o[i], eb);
            check($sformatf("stall_cnt_L%0d", L), scnt_o[i], mscnt[i]);
            check($sformatf("flush_cnt_L%0d", L), fcnt_o[i], mfcnt[i]);
            seen_stall[i]  = stall_o[i];
            seen_busy[i]   = busy_o[i];
            seen_flush[i]  = flush_o[i];
            seen_freeze[i] = freeze_o[i];
            seen_bubble[i] = bubble_o[i];
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            L = lat_of(i);
            if (rst) begin
                phase[i] = -1;
                mscnt[i] = 0;
                mfcnt[i] = 0;
            end else begin
                if (inc_s[i] && mscnt[i] < CMAX) mscnt[i]++;
                if (inc_f[i] && mfcnt[i] < CMAX) mfcnt[i]++;
                if (phase[i] >= 0) begin
                    phase[i]++;
                    if (phase[i] > L - 1) phase[i] = -1;
                end
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        fwd_en = 1'b0; id_two_src = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_wb_en = 1'b0; mem_access = 1'b0; wb_wb_en = 1'b0; branch_taken = 1'b0;
        id_src1 = '0; id_src2 = '0; exe_src1 = '0; exe_src2 = '0;
        exe_dest = '0; mem_dest = '0; wb_dest = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int cnt_a, cnt_b;
        logic [CNT_W-1:0] s_before;
        for (int i = 0; i < N; i++) begin
            phase[i] = -1; mscnt[i] = 0; mfcnt[i] = 0;
        end
        clear_inputs();
        @(posedge clk);
        #1;
        // Reset state
        run_cycle();
        rst = 1'b0;

        // Forwarding: MEM beats WB, then WB, then disabled
        fwd_en = 1'b1; exe_src1 = 4'd3; mem_dest = 4'd3; mem_wb_en = 1'b1;
        wb_dest = 4'd3; wb_wb_en = 1'b1; exe_src2 = 4'd7;
        run_cycle();
        check("fwd_mem_prio", seen_sel1, 2'b01);
        mem_wb_en = 1'b0;
        run_cycle();
        check("fwd_wb", seen_sel1, 2'b10);
        fwd_en = 1'b0;
        run_cycle();
        check("fwd_off", seen_sel1, 2'b00);

        // Load-use hazard through id_src2
        clear_inputs();
        fwd_en = 1'b1; exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd5;
        id_src1 = 4'd1; id_src2 = 4'd5; id_two_src = 1'b1;
        s_before = scnt_o[0];
        run_cycle();
        check("loaduse_freeze", seen_freeze[0], 1'b1);
        check("loaduse_bubble", seen_bubble[0], 1'b1);
        check("loaduse_cnt", scnt_o[0], s_before + 1'b1);
        id_two_src = 1'b0;
        run_cycle();
        check("no_two_src_freeze", seen_freeze[0], 1'b0);
        // Branch beats hazard in the same cycle
        id_two_src = 1'b1; branch_taken = 1'b1;
        run_cycle();
        check("br_vs_haz_flush", seen_flush[0], 1'b1);
        check("br_vs_haz_freeze", seen_freeze[0], 1'b0);
        check("br_vs_haz_bubble", seen_bubble[0], 1'b0);

        // MEM_LAT=4: held access gives 3 stalls, then 3 more for the next access
        do_reset();
        mem_access = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 4; c++) begin
            run_cycle();
            cnt_a += int'(seen_stall[2]);
            cnt_b += int'(seen_stall[2] && seen_busy[2]);
        end
        check("lat4_stall_cycles", cnt_a, 3);
        check("lat4_busy_in_stall", cnt_b, 2);
        cnt_a = 0;
        for (int c = 0; c < 4; c++) begin
            run_cycle();
            cnt_a += int'(seen_stall[2]);
        end
        check("lat4_second_access", cnt_a, 3);

        // MEM_LAT=3: branch held across a stall is flushed once afterwards
        do_reset();
        mem_access = 1'b1; branch_taken = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 3; c++) begin
            run_cycle();
            mem_access = 1'b0;
            cnt_a += int'(seen_stall[1] && !seen_flush[1]);
            cnt_b += int'(seen_flush[1]);
        end
        branch_taken = 1'b0;
        run_cycle();
        check("lat3_stall_noflush", cnt_a, 2);
        check("lat3_flush_once", cnt_b, 1);
        check("lat3_flush_cnt", fcnt_o[1], 1);

        // MEM_LAT=5: reset in the second cycle of an access aborts it
        do_reset();
        mem_access = 1'b1;
        run_cycle();
        run_cycle();
        rst = 1'b1;
        #1;
        check("rst_stall_async", stall_o[3], 1'b0);
        check("rst_scnt_async", scnt_o[3], 0);
        check("rst_busy_async", busy_o[3], 1'b0);
        run_cycle();
        rst = 1'b0;
        cnt_a = 0;
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            cnt_a += int'(seen_stall[3]);
        end
        check("lat5_restart_stalls", cnt_a, 4);

        // Randomised traffic, long enough to saturate the 8-bit counters
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 699) == 0);
            fwd_en       = ($urandom_range(0, 3) != 0);
            id_src1      = REG_W'($urandom_range(0, 3));
            id_src2      = REG_W'($urandom_range(0, 3));
            id_two_src   = 1'($urandom);
            exe_src1     = REG_W'($urandom_range(0, 3));
            exe_src2     = REG_W'($urandom_range(0, 3));
            exe_dest     = REG_W'($urandom_range(0, 3));
            exe_wb_en    = 1'($urandom);
            exe_mem_r_en = 1'($urandom);
            mem_dest     = REG_W'($urandom_range(0, 3));
            mem_wb_en    = 1'($urandom);
            mem_access   = ($urandom_range(0, 4) == 0);
            wb_dest      = REG_W'($urandom_range(0, 3));
            wb_wb_en     = 1'($urandom);
            branch_taken = ($urandom_range(0, 3) == 0);
            run_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
